// File: rtl/array_queue_ctrl_pkg.sv
// array_queue_ctrl_pkg: shared sizes, pointer type and pointer helper for the SRAM-backed queue
// Contents: AQ_DEPTH/AQ_WIDTH defaults, ptr_t ({wrap, idx}), ptr_inc()
package array_queue_ctrl_pkg;
    localparam int AQ_DEPTH = 8;
    localparam int AQ_WIDTH = 256;
    localparam int AQ_AW = $clog2(AQ_DEPTH);
    // wrap bit distinguishes full from empty when the index bits match
    typedef struct packed {
        logic wrap;
        logic [AQ_AW-1:0] idx;
    } ptr_t;
    // DEPTH is a power of two, so a plain increment wraps modulo 2*DEPTH
    function automatic ptr_t ptr_inc(ptr_t p);
        return ptr_t'(p + 1'b1);
    endfunction
endpackage

// File: rtl/array_queue_ctrl_if.sv
// array_queue_ctrl_if: producer/consumer side of the queue
// Signals: flush, enq_valid/enq_ready/enq_bits, deq_valid/deq_ready/deq_bits, count
// Modports: master = producer/consumer, slave = queue
interface array_queue_ctrl_if
    import array_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = AQ_DEPTH,
    parameter int WIDTH = AQ_WIDTH
);
    localparam int CW = $clog2(DEPTH + 2) + 1;
    logic flush;
    logic enq_valid;
    logic enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic deq_valid;
    logic deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0] count;
    modport master (
        output flush, enq_valid, enq_bits, deq_ready,
        input  enq_ready, deq_valid, deq_bits, count
    );
    modport slave (
        input  flush, enq_valid, enq_bits, deq_ready,
        output enq_ready, deq_valid, deq_bits, count
    );
endinterface

// File: rtl/array_queue_obuf.sv
// array_queue_obuf: 2-slot output buffer that hides the SRAM read latency
// Ports: clock, reset (async active-low), flush, capture/cap_data (SRAM read return),
//        deq (head consumed), cnt (occupancy 0..2), valid, head (slot0, registered)
module array_queue_obuf
    import array_queue_ctrl_pkg::*;
#(
    parameter int WIDTH = AQ_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic capture,
    input  logic [WIDTH-1:0] cap_data,
    input  logic deq,
    output logic [1:0] cnt,
    output logic valid,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] slot1;
    logic [1:0] tail;
    // tail slot after this cycle's dequeue shift; with cnt=1 and deq it is slot0
    assign tail = cnt - {1'b0, deq};
    assign valid = cnt != 2'd0;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= 2'd0;
        else if (flush)
            cnt <= 2'd0;
        else
            cnt <= cnt + {1'b0, capture} - {1'b0, deq};
    end
    // data slots are not reset; cnt alone decides what is valid
    always_ff @(posedge clock) begin
        head  <= (capture && tail == 2'd0) ? cap_data : (deq ? slot1 : head);
        slot1 <= (capture && tail == 2'd1) ? cap_data : slot1;
    end
endmodule

// File: rtl/array_queue_ctrl.sv
// array_queue_ctrl: runs a 1R1W synchronous SRAM as a valid/ready FIFO, 1 enq + 1 deq per cycle
// Ports: clock, reset (async active-low), io (slave side of array_queue_ctrl_if),
//        sram_W0_* (write port), sram_R0_* (read port, data one cycle after en)
// DEPTH must match the package default, which sizes ptr_t.
module array_queue_ctrl
    import array_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = AQ_DEPTH,
    parameter int WIDTH = AQ_WIDTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 2) + 1
) (
    input  logic clock,
    input  logic reset,
    array_queue_ctrl_if.slave io,
    output logic sram_W0_en,
    output logic [AW-1:0] sram_W0_addr,
    output logic [WIDTH-1:0] sram_W0_data,
    output logic sram_R0_en,
    output logic [AW-1:0] sram_R0_addr,
    input  logic [WIDTH-1:0] sram_R0_data
);
    ptr_t wptr, rptr;
    logic inflight, enq_fire, deq_fire, rd_issue, full, empty, deq_valid;
    logic [WIDTH-1:0] deq_bits;
    logic [1:0] obuf_cnt;
    logic [AW:0] sram_cnt;
    logic [CW-1:0] obuf_pend;
    assign sram_cnt = wptr - rptr;
    assign full = (wptr.idx == rptr.idx) && (wptr.wrap != rptr.wrap);
    assign empty = wptr == rptr;
    // entries only reach obuf through the SRAM, so SRAM full blocks enq even if obuf has room
    assign io.enq_ready = reset && !full && !io.flush;
    assign enq_fire = io.enq_valid && io.enq_ready;
    assign deq_fire = deq_valid && io.deq_ready && !io.flush;
    // obuf occupancy once the pending capture lands and this cycle's deq leaves
    assign obuf_pend = CW'(obuf_cnt) + CW'(inflight) - CW'(deq_fire);
    // empty ignores the same-cycle write, so a read never hits the address being written
    assign rd_issue = !empty && obuf_pend < CW'(2) && !io.flush;
    assign sram_W0_en = enq_fire;
    assign sram_W0_addr = wptr.idx;
    assign sram_W0_data = io.enq_bits;
    assign sram_R0_en = rd_issue;
    assign sram_R0_addr = rptr.idx;
    assign io.deq_valid = deq_valid;
    assign io.deq_bits = deq_bits;
    assign io.count = CW'(sram_cnt) + CW'(inflight) + CW'(obuf_cnt);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            inflight <= 1'b0;
        end else if (io.flush) begin
            wptr <= '0;
            rptr <= '0;
            inflight <= 1'b0;
        end else begin
            if (enq_fire)
                wptr <= ptr_inc(wptr);
            if (rd_issue)
                rptr <= ptr_inc(rptr);
            inflight <= rd_issue;
        end
    end
    // flush inside obuf drops a read return that lands in the flush cycle
    array_queue_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clock    (clock),
        .reset    (reset),
        .flush    (io.flush),
        .capture  (inflight),
        .cap_data (sram_R0_data),
        .deq      (deq_fire),
        .cnt      (obuf_cnt),
        .valid    (deq_valid),
        .head     (deq_bits)
    );
    a_no_empty_deq: assert property (@(posedge clock) disable iff (!reset) deq_fire |-> obuf_cnt != 2'd0);
    a_inflight_room: assert property (@(posedge clock) disable iff (!reset)
        inflight |-> (CW'(obuf_cnt) - CW'(deq_fire)) < CW'(2));
    a_sram_cnt: assert property (@(posedge clock) disable iff (!reset) sram_cnt <= (AW+1)'(DEPTH));
endmodule

// File: tb/tb_array_queue_ctrl.sv
// tb_array_queue_ctrl: directed and randomised checks of array_queue_ctrl against a queue model
module tb_array_queue_ctrl;
    localparam int DEPTH = 8;
    localparam int W = 256;
    localparam int AW = 3;
    localparam int CW = 5;
    logic clk;
    logic reset;
    logic sram_W0_en, sram_R0_en;
    logic [AW-1:0] sram_W0_addr, sram_R0_addr;
    logic [W-1:0] sram_W0_data, sram_R0_data;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] model_q[$];
    int n_checks, n_errors, n_deq;
    array_queue_ctrl_if #(.DEPTH(DEPTH), .WIDTH(W)) io ();
    array_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clock        (clk),
        .reset        (reset),
        .io           (io.slave),
        .sram_W0_en   (sram_W0_en),
        .sram_W0_addr (sram_W0_addr),
        .sram_W0_data (sram_W0_data),
        .sram_R0_en   (sram_R0_en),
        .sram_R0_addr (sram_R0_addr),
        .sram_R0_data (sram_R0_data)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (sram_W0_en)
            mem[sram_W0_addr] <= sram_W0_data;
        if (sram_R0_en)
            sram_R0_data <= mem[sram_R0_addr];
    end
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask
    // one clock cycle: drive after the edge, check at the falling edge, then update the model
    task automatic step(input logic ev, input logic [W-1:0] eb, input logic dr, input logic fl);
        logic enq_f, deq_f;
        @(posedge clk);
        #1;
        io.enq_valid = ev;
        io.enq_bits = eb;
        io.deq_ready = dr;
        io.flush = fl;
        @(negedge clk);
        enq_f = ev && io.enq_ready;
        deq_f = dr && io.deq_valid && !fl;
        check("count", W'(io.count), W'(model_q.size()));
        if (model_q.size() == 0)
            check("empty_valid", W'(io.deq_valid), W'(0));
        else if (io.deq_valid)
            check("deq_bits", io.deq_bits, model_q[0]);
        if (fl)
            check("flush_ready", W'(io.enq_ready), W'(0));
        else if (model_q.size() < DEPTH)
            check("ready_space", W'(io.enq_ready), W'(1));
        if (model_q.size() == DEPTH + 2)
            check("ready_full", W'(io.enq_ready), W'(0));
        check("w0_en", W'(sram_W0_en), W'(enq_f));
        if (enq_f)
            check("w0_data", sram_W0_data, eb);
        if (fl)
            model_q.delete();
        else begin
            if (deq_f)
                void'(model_q.pop_front());
            if (enq_f)
                model_q.push_back(eb);
        end
        if (deq_f)
            n_deq++;
    endtask
    initial begin
        logic [W-1:0] a5;
        a5 = {32{8'hA5}};
        n_checks = 0;
        n_errors = 0;
        n_deq = 0;
        reset = 1'b0;
        io.enq_valid = 1'b1;
        io.enq_bits = a5;
        io.deq_ready = 1'b1;
        io.flush = 1'b0;
        // reset held with a valid producer: nothing may be written or read
        repeat (2) @(negedge clk);
        check("rst_deq_valid", W'(io.deq_valid), W'(0));
        check("rst_w0_en", W'(sram_W0_en), W'(0));
        check("rst_r0_en", W'(sram_R0_en), W'(0));
        check("rst_count", W'(io.count), W'(0));
        io.enq_valid = 1'b0;
        io.deq_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_enq_ready", W'(io.enq_ready), W'(1));
        check("rst_w0_addr", W'(sram_W0_addr), W'(0));
        check("rst_r0_addr", W'(sram_R0_addr), W'(0));
        // single entry: write c0, read c1, valid c3
        step(1'b1, a5, 1'b0, 1'b0);
        check("single_w0_en", W'(sram_W0_en), W'(1));
        check("single_w0_addr", W'(sram_W0_addr), W'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        check("single_r0_en", W'(sram_R0_en), W'(1));
        check("single_r0_addr", W'(sram_R0_addr), W'(0));
        step(1'b0, '0, 1'b0, 1'b0);
        check("single_c2_valid", W'(io.deq_valid), W'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        check("single_c3_valid", W'(io.deq_valid), W'(1));
        check("single_c3_bits", io.deq_bits, a5);
        check("single_c3_count", W'(io.count), W'(1));
        step(1'b0, '0, 1'b0, 1'b0);
        check("single_after_count", W'(io.count), W'(0));
        // fill: 10 accepted (8 SRAM + 2 obuf), the 11th refused
        for (int i = 0; i < 10; i++)
            step(1'b1, {8{32'h1000 + i}}, 1'b0, 1'b0);
        step(1'b1, {8{32'hDEAD}}, 1'b0, 1'b0);
        check("fill_ready", W'(io.enq_ready), W'(0));
        check("fill_count", W'(io.count), W'(10));
        check("fill_model", W'(model_q.size()), W'(10));
        for (int i = 0; i < 16; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("fill_drained", W'(model_q.size()), W'(0));
        // streaming: one bubble-free deq per cycle after the 3-cycle fill latency
        n_deq = 0;
        for (int i = 0; i < 40; i++)
            step(1'b1, W'(i + 1), 1'b1, 1'b0);
        check("stream_deqs", W'(n_deq), W'(37));
        for (int i = 0; i < 6; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("stream_drained", W'(model_q.size()), W'(0));
        // random traffic against the model
        for (int i = 0; i < 1000; i++)
            step(1'($urandom_range(0, 1)), {8{$urandom}}, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("rand_drained", W'(model_q.size()), W'(0));
        // flush with 1 in obuf, 1 in flight and 5 in SRAM; enq/deq in the flush cycle are ignored
        for (int i = 0; i < 8; i++)
            step(1'b1, {8{32'h2000 + i}}, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_r0_en", W'(sram_R0_en), W'(1));
        step(1'b1, {8{32'hBAD}}, 1'b1, 1'b1);
        check("flush_w0_en", W'(sram_W0_en), W'(0));
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_next_count", W'(io.count), W'(0));
        check("flush_next_valid", W'(io.deq_valid), W'(0));
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, W'(1), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("flush_post_bits", io.deq_bits, W'(1));
        check("flush_post_valid", W'(io.deq_valid), W'(1));
        step(1'b0, '0, 1'b0, 1'b0);
        check("flush_post_empty", W'(model_q.size()), W'(0));
        // async reset mid-stream, no clock edge in between
        for (int i = 0; i < 6; i++)
            step(1'b1, W'(100 + i), 1'b1, 1'b0);
        check("pre_rst_r0_en", W'(sram_R0_en), W'(1));
        #2;
        reset = 1'b0;
        #1;
        check("arst_deq_valid", W'(io.deq_valid), W'(0));
        check("arst_w0_en", W'(sram_W0_en), W'(0));
        check("arst_r0_en", W'(sram_R0_en), W'(0));
        check("arst_count", W'(io.count), W'(0));
        model_q.delete();
        io.enq_valid = 1'b0;
        io.deq_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_rel_count", W'(io.count), W'(0));
        step(1'b1, W'(32'h77), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, '0, 1'b1, 1'b0);
        check("arst_post_empty", W'(model_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
